key_event_gen: RTL and testbench
================================

// Module: key_event_gen
// PURPOSE
//  Front end for the clock-setting pushbuttons: turns raw, bouncing, active-low keys
//  into clean per-key events for the time counter/display block.
//  Per key: 2-FF sync, debounce, debounced level, press/release pulses, auto-repeat.
//  Consumers advance min/hour once per key_evt pulse; they need no edge detection.
// PARAMETERS
//  N_KEYS           4           number of independent keys
//  DEBOUNCE_CYC     1_000_000   cycles the synced input must be stable (20 ms @ 50 MHz)
//  REPEAT_DELAY_CYC 25_000_000  cycles from key_press to first key_repeat (500 ms)
//  REPEAT_RATE_CYC  5_000_000   cycles between subsequent key_repeat pulses (100 ms)
//  REPEAT_EN        4'b1111     per-key auto-repeat enable mask
//  CNT_W            25          counter width; must hold max of the three cycle counts
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  key_n        in   N_KEYS  raw keys, 0 = pressed, asynchronous to clk
//  key_level    out  N_KEYS  debounced level, 1 = pressed
//  key_press    out  N_KEYS  1-cycle pulse on debounced press
//  key_release  out  N_KEYS  1-cycle pulse on debounced release
//  key_repeat   out  N_KEYS  1-cycle pulse per auto-repeat tick
//  key_evt      out  N_KEYS  key_press | key_repeat (registered, same cycle)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0; sync flops 1 (released); counters 0; FSMs IDLE.
//  - Sync: s0<=~key_n... two flops; "sampled" = second flop, inverted (1 = pressed).
//  - Debounce per key: counter clears whenever sampled == key_level; otherwise increments;
//    when it reaches DEBOUNCE_CYC-1 and sampled still differs, key_level toggles, counter clears.
//    Any glitch back to key_level value before that restarts the count from 0.
//  - Latency: key_n held low from edge 0 -> key_level=1 and key_press=1 at edge 2+DEBOUNCE_CYC.
//    Same latency for release -> key_level=0 and key_release=1.
//  - key_press/key_release asserted exactly one cycle, in the cycle key_level changes.
//  - Repeat FSM per key, states: IDLE, DELAY, REPEAT.
//    IDLE  -> DELAY on key_press (repeat counter cleared), only if REPEAT_EN[k].
//    DELAY: counts; at REPEAT_DELAY_CYC cycles after key_press: key_repeat pulse, -> REPEAT.
//    REPEAT: pulse every REPEAT_RATE_CYC cycles after previous pulse.
//    DELAY/REPEAT -> IDLE on key_release; no key_repeat in or after the release cycle.
//  - key_press and key_repeat never coincide for one key; key_evt is their OR.
//  - Keys fully independent: simultaneous events on several keys all reported same cycle.
//  - Repeat counter saturates nowhere: it restarts after each pulse, so holding is unbounded.
//  - Reset mid-hold: outputs drop to 0 immediately; after release of rst_n a still-held
//    key is reported as a fresh press after 2+DEBOUNCE_CYC cycles.
//  - Key already pressed when reset releases counts as press (sync reset value = released).
// TESTING  (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3, edge 0 = key change)
//  1 key_n[0] 1->0 held -> key_level[0]=1, key_press[0]=key_evt[0]=1 only at edge 6.
//  2 key_n[1] toggles every 2 cycles x5, then held 0 -> one key_press[1], 6 edges after last
//    toggle; no pulses during bounce; key_level stays 0 throughout bounce.
//  3 key_n[2] held 40 cycles -> key_press at 6, key_repeat at 16,19,22,...,43; key_evt = union.
//  4 key_n[2] released at cycle 30 of hold -> key_release at +6, key_repeat stops, level 0.
//  5 key_n[0],key_n[3] fall same edge, REPEAT_EN=4'b0111 -> both key_press at 6;
//    key_repeat[0] at 16, key_repeat[3] never.
//  6 rst_n=0 for 3 cycles during hold -> outputs 0 immediately; key still low ->
//    key_press re-issued 6 edges after rst_n rises; no key_release emitted for the reset.

Source files
------------

// File: rtl/key_event_gen_if.sv
// Purpose: key bundle between the pushbutton pins and the clock-setting logic.
// Latency: none, wires only.
// Backpressure: none; events are single-cycle pulses that the consumer must take.
interface key_event_gen_if #(
  parameter int N_KEYS = 4
);

  logic [N_KEYS-1:0] key_n;        // raw keys, 0 = pressed, asynchronous
  logic [N_KEYS-1:0] key_level;    // debounced level, 1 = pressed
  logic [N_KEYS-1:0] key_press;    // one-cycle pulse on debounced press
  logic [N_KEYS-1:0] key_release;  // one-cycle pulse on debounced release
  logic [N_KEYS-1:0] key_repeat;   // one-cycle pulse per auto-repeat tick
  logic [N_KEYS-1:0] key_evt;      // key_press | key_repeat

  // Key source side: drives the raw pins and observes the events.
  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat,
    input  key_evt
  );

  // Event generator side.
  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat,
    output key_evt
  );

endinterface

// File: rtl/key_event_gen.sv
// Purpose: per-key 2-FF sync, debounce, press/release pulses and auto-repeat.
// Latency: key_n edge to key_level/key_press is 2 + DEBOUNCE_CYC cycles; all outputs registered.
// Backpressure: none; every event is a one-cycle pulse that the consumer must take.
module key_event_gen #(
  parameter int                N_KEYS           = 4,
  parameter int                DEBOUNCE_CYC     = 1_000_000,
  parameter int                REPEAT_DELAY_CYC = 25_000_000,
  parameter int                REPEAT_RATE_CYC  = 5_000_000,
  parameter logic [N_KEYS-1:0] REPEAT_EN        = {N_KEYS{1'b1}},
  parameter int                CNT_W            = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  key_event_gen_if.slave   bus
);

  // Terminal counts. A counter that has reached *_LAST fires on the next edge.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  // Synchronizer, kept in raw key polarity so reset (1) means "released".
  logic [N_KEYS-1:0] sync0_q;
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sampled;      // 1 = pressed

  // Debounce state.
  logic [CNT_W-1:0]  db_cnt_q [N_KEYS];
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] release_q;

  // Auto-repeat state.
  rpt_state_e        rpt_st_q  [N_KEYS];
  logic [CNT_W-1:0]  rpt_cnt_q [N_KEYS];
  logic [N_KEYS-1:0] repeat_q;
  logic [N_KEYS-1:0] evt_q;

  // Next-state decode shared by the debounce and repeat blocks.
  logic [N_KEYS-1:0] db_diff;
  logic [N_KEYS-1:0] db_hit;
  logic [N_KEYS-1:0] press_d;
  logic [N_KEYS-1:0] release_d;
  logic [N_KEYS-1:0] repeat_d;

  assign sampled = ~sync1_q;

  // Two-flop synchronizer for the asynchronous key pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '1;
      sync1_q <= '1;
    end else begin
      sync0_q <= bus.key_n;
      sync1_q <= sync0_q;
    end
  end

  // Decode debounce completion and repeat ticks for every key this cycle.
  always_comb begin
    db_diff   = '0;
    db_hit    = '0;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      db_diff[k]   = sampled[k] ^ level_q[k];
      db_hit[k]    = db_diff[k] && (db_cnt_q[k] == DEB_LAST);
      press_d[k]   = db_hit[k] & ~level_q[k];
      release_d[k] = db_hit[k] &  level_q[k];
      // A release in the same cycle wins: no tick in or after the release cycle.
      repeat_d[k]  = !release_d[k] &&
                     (((rpt_st_q[k] == RPT_DELAY)  && (rpt_cnt_q[k] == DLY_LAST)) ||
                      ((rpt_st_q[k] == RPT_REPEAT) && (rpt_cnt_q[k] == RATE_LAST)));
    end
  end

  // Debounce: count consecutive cycles the synced key disagrees with the level;
  // any agreement restarts the count, reaching the terminal count flips the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      level_q   <= level_q ^ db_hit;
      press_q   <= press_d;
      release_q <= release_d;
      for (int k = 0; k < N_KEYS; k++) begin
        if (!db_diff[k] || db_hit[k]) begin
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // Auto-repeat FSM per key: initial delay after the press, then a fixed rate
  // until release. The counter restarts after every tick so holds are unbounded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_q <= '0;
      evt_q    <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        rpt_st_q[k]  <= RPT_IDLE;
        rpt_cnt_q[k] <= '0;
      end
    end else begin
      repeat_q <= repeat_d;
      evt_q    <= press_d | repeat_d;
      for (int k = 0; k < N_KEYS; k++) begin
        if (release_d[k]) begin
          rpt_st_q[k]  <= RPT_IDLE;
          rpt_cnt_q[k] <= '0;
        end else begin
          case (rpt_st_q[k])
            RPT_IDLE: begin
              rpt_cnt_q[k] <= '0;
              if (press_d[k] && REPEAT_EN[k]) begin
                rpt_st_q[k] <= RPT_DELAY;
              end
            end
            RPT_DELAY: begin
              if (repeat_d[k]) begin
                rpt_st_q[k]  <= RPT_REPEAT;
                rpt_cnt_q[k] <= '0;
              end else begin
                rpt_cnt_q[k] <= rpt_cnt_q[k] + CNT_W'(1);
              end
            end
            RPT_REPEAT: begin
              if (repeat_d[k]) begin
                rpt_cnt_q[k] <= '0;
              end else begin
                rpt_cnt_q[k] <= rpt_cnt_q[k] + CNT_W'(1);
              end
            end
            default: begin
              rpt_st_q[k]  <= RPT_IDLE;
              rpt_cnt_q[k] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.key_repeat  = repeat_q;
  assign bus.key_evt     = evt_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Purpose: directed and random key stimulus checked against a window/arithmetic reference model.
// Latency: expected press/release 2 + DEBOUNCE_CYC edges after the raw change.
// Backpressure: none; outputs compared every cycle, 1 ns after the rising edge.
module tb_key_event_gen;

  localparam int         NK   = 4;
  localparam int         DEB  = 4;
  localparam int         DLY  = 10;
  localparam int         RATE = 3;
  localparam logic [3:0] EN   = 4'b0111;
  localparam int         MAXC = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  key_event_gen_if #(.N_KEYS(NK)) kif ();

  key_event_gen #(
    .N_KEYS           (NK),
    .DEBOUNCE_CYC     (DEB),
    .REPEAT_DELAY_CYC (DLY),
    .REPEAT_RATE_CYC  (RATE),
    .REPEAT_EN        (EN),
    .CNT_W            (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // raw_h[c] = pressed flags driven just after edge c (forced released while in reset).
  logic [NK-1:0] raw_h [MAXC];
  logic [NK-1:0] m_level, m_press, m_rel, m_rpt, m_evt;
  int            press_t [NK];

  // Pressed flag the debouncer sees at edge e: raw value from three edges earlier.
  function automatic logic smp(int e, int k);
    if (e - 3 < 0 || e - 3 >= MAXC) return 1'b0;
    return raw_h[e - 3][k];
  endfunction

  task automatic model_zero();
    m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_evt = '0;
  endtask

  // Reference: a level flips once the last DEB samples all disagree with it;
  // repeats fall at press + DLY + n*RATE while the key is held and enabled.
  task automatic model_edge();
    if (!rst_n) begin
      model_zero();
    end else begin
      for (int k = 0; k < NK; k++) begin
        logic all_diff;
        int   d;
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          if (smp(cyc - j, k) == m_level[k]) all_diff = 1'b0;
        end
        m_press[k] = all_diff && !m_level[k];
        m_rel[k]   = all_diff &&  m_level[k];
        if (all_diff) m_level[k] = ~m_level[k];
        if (m_press[k]) press_t[k] = cyc;
        m_rpt[k] = 1'b0;
        if (m_level[k] && EN[k] && !m_press[k]) begin
          d = cyc - press_t[k] - DLY;
          if (d >= 0 && (d % RATE) == 0) m_rpt[k] = 1'b1;
        end
      end
      m_evt = m_press | m_rpt;
    end
  endtask

  task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    chk("key_level",   kif.key_level,   m_level);
    chk("key_press",   kif.key_press,   m_press);
    chk("key_release", kif.key_release, m_rel);
    chk("key_repeat",  kif.key_repeat,  m_rpt);
    chk("key_evt",     kif.key_evt,     m_evt);
  endtask

  // One clock: model the edge, compare, then drive the next key/reset values.
  task automatic step(input logic [NK-1:0] kn, input logic rn);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
    rst_n     = rn;
    kif.key_n = kn;
    if (!rn) begin
      model_zero();
      #1;
      check_all();
    end
    if (cyc < MAXC) raw_h[cyc] = rn ? ~kn : '0;
  endtask

  task automatic hold(input logic [NK-1:0] kn, input int n);
    repeat (n) step(kn, 1'b1);
  endtask

  initial begin
    logic [NK-1:0] kn;
    for (int c = 0; c < MAXC; c++) raw_h[c] = '0;
    for (int k = 0; k < NK; k++) press_t[k] = 0;
    model_zero();
    kif.key_n = '1;

    // Reset state.
    repeat (3) step(4'b1111, 1'b0);
    hold(4'b1111, 4);

    // Single clean press and release of key 0.
    hold(4'b1110, 12);
    hold(4'b1111, 12);

    // Key 1 bounces every 2 cycles, then settles pressed.
    for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? 4'b1101 : 4'b1111, 2);
    hold(4'b1101, 12);
    hold(4'b1111, 12);

    // Key 2 long hold with auto-repeat, then a shorter hold.
    hold(4'b1011, 40);
    hold(4'b1111, 12);
    hold(4'b1011, 30);
    hold(4'b1111, 12);

    // Keys 0 and 3 together; key 3 has repeat disabled.
    hold(4'b0110, 25);
    hold(4'b1111, 12);

    // Reset in the middle of a hold on key 1.
    hold(4'b1101, 15);
    repeat (3) step(4'b1101, 1'b0);
    hold(4'b1101, 15);
    hold(4'b1111, 12);

    // Random segments alternating heavy bounce and long holds, one reset pulse.
    kn = '1;
    for (int seg = 0; seg < 8; seg++) begin
      int p;
      p = (seg % 2 == 0) ? 2 : 25;
      for (int c = 0; c < 100; c++) begin
        for (int k = 0; k < NK; k++) begin
          if ($urandom_range(p - 1) == 0) kn[k] = ~kn[k];
        end
        step(kn, !(seg == 5 && c >= 50 && c < 53));
      end
    end
    hold(4'b1111, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
